bias_fetch_ctrl: RTL and testbench

BIAS_FETCH_CTRL -- requirements
Module: bias_fetch_ctrl

---
 rtl/bias_fetch_ctrl.sv | 156 +++++++++++++++
 tb/tb_bias_fetch_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bias_fetch_ctrl.sv
// Bias SRAM load/fetch controller: host writes bias words into a single-port SRAM,
// a fetch command then streams a contiguous range out through a 2-entry skid FIFO.
module bias_fetch_ctrl #(
   parameter int BW_WORD = 64,
   parameter int DEPTH   = 45,
   parameter int ADDR_BW = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wr_valid,
   output logic               wr_ready,
   input  logic [ADDR_BW-1:0] wr_addr,
   input  logic [BW_WORD-1:0] wr_data,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [ADDR_BW-1:0] cmd_base,
   input  logic [ADDR_BW-1:0] cmd_len,
   output logic               bias_valid,
   input  logic               bias_ready,
   output logic [BW_WORD-1:0] bias_data,
   output logic               bias_last,
   output logic               done,
   output logic               err,
   output logic               sram_csb,
   output logic               sram_wsb,
   output logic [ADDR_BW-1:0] sram_waddr,
   output logic [ADDR_BW-1:0] sram_raddr,
   output logic [BW_WORD-1:0] sram_wdata,
   input  logic [BW_WORD-1:0] sram_rdata
);

   typedef enum logic {IDLE, FETCH} state_e;

   localparam logic [ADDR_BW:0] DEPTH_C = (ADDR_BW+1)'(DEPTH);
   localparam logic [ADDR_BW:0] ONE_C   = (ADDR_BW+1)'(1);

   state_e             state_q;
   logic [ADDR_BW-1:0] base_q;
   logic [ADDR_BW:0]   len_q;
   logic [ADDR_BW:0]   issued_q;
   logic [ADDR_BW:0]   beat_q;
   logic               rd_pend_q;
   logic [1:0]         cnt_q;
   logic               wptr_q;
   logic               rptr_q;
   logic [BW_WORD-1:0] mem_q [2];
   logic               done_q;
   logic               err_q;
   logic [ADDR_BW-1:0] waddr_q;
   logic [ADDR_BW-1:0] raddr_q;
   logic [BW_WORD-1:0] wdata_q;

   logic               idle;
   logic               wr_fire;
   logic               wr_ok;
   logic               cmd_fire;
   logic               cmd_ok;
   logic [ADDR_BW:0]   cmd_end;
   logic               pop;
   logic               last_xfer;
   logic [1:0]         cnt_d;
   logic               rd_issue;
   logic [ADDR_BW-1:0] rd_addr;

   // Handshakes are gated by rst_n so nothing reaches the SRAM while reset is held.
   assign idle      = rst_n && (state_q == IDLE);
   assign wr_ready  = idle;
   assign cmd_ready = idle && !wr_valid;
   assign wr_fire   = wr_valid && wr_ready;
   assign wr_ok     = wr_fire && ({1'b0, wr_addr} < DEPTH_C);
   assign cmd_fire  = cmd_valid && cmd_ready;
   assign cmd_end   = {1'b0, cmd_base} + {1'b0, cmd_len};
   assign cmd_ok    = cmd_fire && (cmd_len != '0) && (cmd_end <= DEPTH_C);

   assign bias_valid = (cnt_q != 2'd0);
   assign bias_data  = mem_q[rptr_q];
   assign bias_last  = bias_valid && (beat_q == len_q - ONE_C);
   assign pop        = bias_valid && bias_ready;
   assign last_xfer  = pop && (beat_q == len_q - ONE_C);

   // Occupancy after this cycle's pop plus the read landing this edge; a new read
   // may only go out if that still leaves a free FIFO slot for its data.
   assign cnt_d    = cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
   assign rd_issue = (state_q == FETCH) && (issued_q < len_q) && (cnt_d < 2'd2);
   assign rd_addr  = base_q + issued_q[ADDR_BW-1:0];

   assign sram_csb   = !(wr_ok || rd_issue);
   assign sram_wsb   = !wr_ok;
   assign sram_waddr = wr_ok ? wr_addr : waddr_q;
   assign sram_wdata = wr_ok ? wr_data : wdata_q;
   assign sram_raddr = rd_issue ? rd_addr : raddr_q;
   assign done       = done_q;
   assign err        = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         base_q    <= '0;
         len_q     <= '0;
         issued_q  <= '0;
         beat_q    <= '0;
         rd_pend_q <= 1'b0;
         cnt_q     <= 2'd0;
         wptr_q    <= 1'b0;
         rptr_q    <= 1'b0;
         mem_q[0]  <= '0;
         mem_q[1]  <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         waddr_q   <= '0;
         raddr_q   <= '0;
         wdata_q   <= '0;
      end else begin
         done_q    <= 1'b0;
         rd_pend_q <= rd_issue;
         cnt_q     <= cnt_d;
         if ((wr_fire && !wr_ok) || (cmd_fire && !cmd_ok))
            err_q <= 1'b1;
         if (wr_ok) begin
            waddr_q <= wr_addr;
            wdata_q <= wr_data;
         end
         if (rd_issue) begin
            raddr_q  <= rd_addr;
            issued_q <= issued_q + ONE_C;
         end
         if (rd_pend_q) begin
            mem_q[wptr_q] <= sram_rdata;
            wptr_q        <= ~wptr_q;
         end
         if (pop) begin
            rptr_q <= ~rptr_q;
            beat_q <= beat_q + ONE_C;
         end
         case (state_q)
            IDLE: begin
               if (cmd_ok) begin
                  base_q   <= cmd_base;
                  len_q    <= {1'b0, cmd_len};
                  issued_q <= '0;
                  beat_q   <= '0;
                  state_q  <= FETCH;
               end
            end
            FETCH: begin
               if (last_xfer) begin
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bias_fetch_ctrl.sv
// Scoreboard bench for bias_fetch_ctrl with a behavioural 1-cycle-latency SRAM.
module tb_bias_fetch_ctrl;

   localparam int BW = 64;
   localparam int DP = 45;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wr_valid, wr_ready;
   logic [AW-1:0] wr_addr;
   logic [BW-1:0] wr_data;
   logic          cmd_valid, cmd_ready;
   logic [AW-1:0] cmd_base, cmd_len;
   logic          bias_valid, bias_ready, bias_last;
   logic [BW-1:0] bias_data;
   logic          done, err;
   logic          sram_csb, sram_wsb;
   logic [AW-1:0] sram_waddr, sram_raddr;
   logic [BW-1:0] sram_wdata, sram_rdata;

   bias_fetch_ctrl #(.BW_WORD(BW), .DEPTH(DP), .ADDR_BW(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base), .cmd_len(cmd_len),
      .bias_valid(bias_valid), .bias_ready(bias_ready), .bias_data(bias_data), .bias_last(bias_last),
      .done(done), .err(err),
      .sram_csb(sram_csb), .sram_wsb(sram_wsb), .sram_waddr(sram_waddr), .sram_raddr(sram_raddr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   always #5 clk = ~clk;

   logic [BW-1:0] sram_mem [64];
   always @(posedge clk) begin
      if (!sram_csb) begin
         if (!sram_wsb) sram_mem[sram_waddr] <= sram_wdata;
         else           sram_rdata <= sram_mem[sram_raddr];
      end
   end

   int            n_checks = 0;
   int            n_errors = 0;
   logic [BW-1:0] exp_mem [DP];
   logic [BW:0]   exp_q [$];
   int            n_wr = 0, n_rd = 0, n_bt = 0, max_ahead = 0;
   logic          prev_stall = 1'b0;
   logic [BW-1:0] prev_data;

   task automatic check_eq(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [BW:0] e;
      if (!rst_n) begin
         n_rd = 0; n_bt = 0; prev_stall = 1'b0;
      end else begin
         if (cmd_valid && cmd_ready) max_ahead = 0;
         if (prev_stall) begin
            check_eq("hold_valid", BW'(bias_valid), 1);
            check_eq("hold_data", bias_data, prev_data);
         end
         if (!sram_csb && !sram_wsb) n_wr++;
         if (!sram_csb && sram_wsb)  n_rd++;
         if (bias_valid && bias_ready) begin
            n_bt++;
            if (exp_q.size() == 0) check_eq("extra_beat", 1, 0);
            else begin
               e = exp_q.pop_front();
               check_eq("beat_data", bias_data, e[BW-1:0]);
               check_eq("beat_last", BW'(bias_last), BW'(e[BW]));
            end
         end
         if (n_rd - n_bt > max_ahead) max_ahead = n_rd - n_bt;
         prev_stall = bias_valid && !bias_ready;
         prev_data  = bias_data;
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic write_word(input logic [AW-1:0] a, input logic [BW-1:0] d,
                             output logic csb, output logic wsb, output logic rdy);
      wr_valid = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      csb = sram_csb; wsb = sram_wsb; rdy = wr_ready;
      @(posedge clk); #1;
      wr_valid = 1'b0;
      if (int'(a) < DP) exp_mem[a] = d;
   endtask

   task automatic send_cmd(input logic [AW-1:0] b, input logic [AW-1:0] l);
      logic acc = 1'b0;
      cmd_valid = 1'b1; cmd_base = b; cmd_len = l;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cmd_ready) begin acc = 1'b1; break; end
         @(posedge clk); #1;
      end
      check_eq("cmd_accept", BW'(acc), 1);
      if (acc && l != 0 && int'(b) + int'(l) <= DP)
         for (int k = 0; k < int'(l); k++)
            exp_q.push_back({(k == int'(l) - 1), exp_mem[int'(b) + k]});
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   // mode 0: ready always high; mode 1: ready pattern 1,0,0,1,0,0,...
   task automatic run_stream(input int n, input int mode, input int budget);
      int first = -1, last = -1, dn = -1, ndone = 0, nb = 0;
      bias_ready = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bias_valid && bias_ready) begin
            if (first < 0) first = i;
            nb++;
            if (bias_last) last = i;
         end
         if (done) begin ndone++; if (dn < 0) dn = i; end
         if (dn >= 0 && i > dn) break;
         @(posedge clk); #1;
         bias_ready = (mode == 0) ? 1'b1 : (((i + 1) % 3) == 0);
      end
      check_eq("beat_count", BW'(nb), BW'(n));
      check_eq("done_pulses", BW'(ndone), 1);
      check_eq("done_after_last", BW'(dn), BW'(last + 1));
      check_eq("ahead_le2", BW'(max_ahead <= 2), 1);
      check_eq("sb_empty", BW'(exp_q.size()), 0);
      if (mode == 0) begin
         check_eq("first_valid_lat", BW'(first), 2);
         check_eq("last_beat_idx", BW'(last), BW'(2 + n - 1));
      end
      @(posedge clk); #1;
   endtask

   task automatic bad_cmd(input logic [AW-1:0] b, input logic [AW-1:0] l);
      int nv = 0;
      send_cmd(b, l);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bias_valid || !sram_csb) nv++;
      end
      check_eq("bad_cmd_quiet", BW'(nv), 0);
      check_eq("bad_cmd_idle", BW'(cmd_ready), 1);
      check_eq("bad_cmd_err", BW'(err), 1);
      @(posedge clk); #1;
   endtask

   initial begin
      logic csb, wsb, rdy;
      int   wr_before, nb, bad;
      wr_valid = 0; wr_addr = '0; wr_data = '0;
      cmd_valid = 0; cmd_base = '0; cmd_len = '0; bias_ready = 1'b1;
      rst_n = 1'b0;
      #2;
      check_eq("rst_valid", BW'(bias_valid), 0);
      check_eq("rst_last", BW'(bias_last), 0);
      check_eq("rst_done", BW'(done), 0);
      check_eq("rst_err", BW'(err), 0);
      check_eq("rst_csb", BW'(sram_csb), 1);
      check_eq("rst_wsb", BW'(sram_wsb), 1);
      check_eq("rst_waddr", BW'(sram_waddr), 0);
      check_eq("rst_raddr", BW'(sram_raddr), 0);
      check_eq("rst_wdata", sram_wdata, 0);
      check_eq("rst_bdata", bias_data, 0);
      do_reset();

      // Load all words; probe the combinational write strobe on the first one.
      wr_valid = 1'b1; wr_addr = 6'd7; wr_data = 64'h0707070707070707;
      @(negedge clk);
      check_eq("wr_csb", BW'(sram_csb), 0);
      check_eq("wr_wsb", BW'(sram_wsb), 0);
      check_eq("wr_waddr", BW'(sram_waddr), 7);
      check_eq("wr_wdata", sram_wdata, 64'h0707070707070707);
      check_eq("wr_cmd_blocked", BW'(cmd_ready), 0);
      @(posedge clk); #1;
      wr_valid = 1'b0;
      exp_mem[7] = 64'h0707070707070707;
      for (int a = 0; a < DP; a++)
         write_word(AW'(a), 64'(a) * 64'h0101010101010101, csb, wsb, rdy);
      @(negedge clk);
      check_eq("write_count", BW'(n_wr), BW'(DP + 1));
      @(posedge clk); #1;

      send_cmd(6'd0, 6'd45);
      run_stream(45, 0, 80);
      check_eq("err_clean", BW'(err), 0);

      // Write and command together: write wins, command follows next cycle.
      wr_valid = 1'b1; wr_addr = 6'd21; wr_data = 64'hDEADBEEF00000015;
      cmd_valid = 1'b1; cmd_base = 6'd20; cmd_len = 6'd3;
      @(negedge clk);
      check_eq("both_wr_ready", BW'(wr_ready), 1);
      check_eq("both_cmd_ready", BW'(cmd_ready), 0);
      check_eq("both_csb", BW'(sram_csb), 0);
      @(posedge clk); #1;
      wr_valid = 1'b0;
      exp_mem[21] = 64'hDEADBEEF00000015;
      send_cmd(6'd20, 6'd3);
      run_stream(3, 0, 40);

      send_cmd(6'd10, 6'd4);
      run_stream(4, 1, 60);

      wr_before = n_wr;
      write_word(6'd45, 64'hFFFF, csb, wsb, rdy);
      check_eq("badwr_ready", BW'(rdy), 1);
      check_eq("badwr_csb", BW'(csb), 1);
      @(negedge clk);
      check_eq("badwr_err", BW'(err), 1);
      check_eq("badwr_nowrite", BW'(n_wr), BW'(wr_before));
      @(posedge clk); #1;
      do_reset();
      bad_cmd(6'd40, 6'd6);
      do_reset();
      bad_cmd(6'd10, 6'd0);
      repeat (4) @(posedge clk);
      #1 check_eq("err_sticky", BW'(err), 1);
      do_reset();

      // Abort a long fetch with reset after its third beat.
      send_cmd(6'd0, 6'd20);
      bias_ready = 1'b1;
      nb = 0;
      for (int i = 0; i < 40 && nb < 3; i++) begin
         @(negedge clk);
         if (bias_valid && bias_ready) nb++;
         if (nb < 3) begin @(posedge clk); #1; end
      end
      check_eq("abort_3beats", BW'(nb), 3);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check_eq("abort_valid", BW'(bias_valid), 0);
      check_eq("abort_csb", BW'(sram_csb), 1);
      check_eq("abort_last", BW'(bias_last), 0);
      exp_q.delete();
      bad = 0;
      repeat (2) begin
         @(negedge clk);
         if (done || bias_valid || !sram_csb) bad++;
      end
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (done || bias_valid || !sram_csb) bad++;
      end
      check_eq("abort_quiet", BW'(bad), 0);
      @(posedge clk); #1;
      send_cmd(6'd0, 6'd1);
      run_stream(1, 0, 20);
      check_eq("final_err", BW'(err), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
